bldc_speed_ctrl: RTL

//  Closed-loop DC/BLDC speed controller. Decodes a quadrature encoder into signed counts and measures signed

---
 rtl/bldc_pkg.sv | 38 +++
 rtl/bldc_quad_decoder.sv | 59 +++++
 rtl/bldc_speed_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bldc_pkg.sv
// Shared types and saturating arithmetic helpers for the BLDC speed controller.
package bldc_pkg;

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        MP   = 3'd2,
        MI   = 3'd3,
        MD   = 3'd4,
        OUT  = 3'd5
    } ctrl_state_t;

    // Saturate a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                                 input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Symmetric clamp to +/-lim, lim assumed non-negative.
    function automatic logic signed [63:0] clamp_s(input logic signed [63:0] v,
                                                   input logic signed [63:0] lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

endpackage

// File: rtl/bldc_quad_decoder.sv
// Quadrature encoder front end: two-stage synchronisers, Gray-code step decode
// (+1 forward 00>01>11>10, -1 reverse) and a sticky flag for illegal double changes.
module bldc_quad_decoder
    import bldc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enc_a,
    input  logic              i_enc_b,
    output logic signed [1:0] o_step,
    output logic              o_enc_error
);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic       r_err;
    logic [1:0] w_diff;

    // Position of a {A,B} Gray code along the forward sequence.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        case (g)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Distance moved since last clock, modulo 4; 2 means both pins changed.
    assign w_diff      = gray_pos(r_sync2) - gray_pos(r_prev);
    assign o_enc_error = r_err;

    // Synchronise pins, remember last state, latch illegal transitions until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_prev  <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= {i_enc_a, i_enc_b};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_diff == 2'd2) r_err <= 1'b1;
        end
    end

    // Map the modular distance onto a signed step; double changes count as zero.
    always_comb begin
        o_step = 2'sb00;
        case (w_diff)
            2'd1:    o_step = 2'sb01;
            2'd3:    o_step = 2'sb11;
            default: o_step = 2'sb00;
        endcase
    end

endmodule

// File: rtl/bldc_speed_ctrl.sv
// Closed-loop speed controller: encoder speed window, shared-multiplier PID with
// anti-windup, and a direction-aware PWM pair with deadtime on reversal.
module bldc_speed_ctrl
    import bldc_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int FRAC_BITS      = 8,
    parameter int SAMPLE_PERIODS = 4,
    parameter int INT_LIMIT      = 2047,
    parameter int DEADTIME       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pwm_en,
    input  logic                  encoder_a,
    input  logic                  encoder_b,
    input  logic [DATA_WIDTH-1:0] pwm_period,
    input  logic [DATA_WIDTH-1:0] speed_reference,
    input  logic [DATA_WIDTH-1:0] Kp,
    input  logic [DATA_WIDTH-1:0] Ki,
    input  logic [DATA_WIDTH-1:0] Kd,
    output logic                  motor_positive,
    output logic                  motor_negative,
    output logic [DATA_WIDTH-1:0] speed_meas,
    output logic [DATA_WIDTH:0]   duty_cmd,
    output logic                  enc_error
);

    localparam int DW  = DATA_WIDTH;
    localparam int DW1 = DATA_WIDTH + 1;
    localparam int AW  = 2 * DATA_WIDTH + 4;
    localparam int WW  = (SAMPLE_PERIODS > 1) ? $clog2(SAMPLE_PERIODS) : 1;
    localparam int DTW = (DEADTIME > 1) ? $clog2(DEADTIME) + 1 : 1;
    localparam logic [WW-1:0]      SP_LAST   = WW'(SAMPLE_PERIODS - 1);
    localparam logic [DTW-1:0]     DT_LOAD   = DTW'((DEADTIME > 0) ? DEADTIME - 1 : 0);
    localparam logic signed [63:0] INT_LIM64 = 64'(INT_LIMIT);

    logic signed [1:0]      w_step;
    logic [DW-1:0]          r_cnt;
    logic [WW-1:0]          r_win;
    logic                   w_wrap;
    logic                   w_start;
    logic signed [DW-1:0]   r_acc_win;
    logic signed [DW-1:0]   w_acc_next;
    logic signed [DW-1:0]   r_speed_meas;

    ctrl_state_t            r_state;
    logic [DW-1:0]          r_kp, r_ki, r_kd;
    logic signed [DW-1:0]   r_e, r_prev_e, r_integral;
    logic signed [AW-1:0]   r_acc;
    logic signed [DW:0]     r_duty_cmd;
    logic signed [DW:0]     w_mul_a, w_mul_b, w_de;
    logic signed [2*DW1-1:0] w_prod;
    logic signed [63:0]     w_y64, w_lim64, w_ycl64;
    logic                   w_y_sat, w_freeze;

    logic signed [DW:0]     r_duty_active;
    logic [DW:0]            w_duty_mag;
    logic                   w_pwm;
    dir_t                   r_dir, w_want_dir;
    logic [DTW-1:0]         r_dt_cnt;
    logic                   r_mpos, r_mneg;

    bldc_quad_decoder u_dec (
        .clk        (clk),
        .reset      (reset),
        .i_enc_a    (encoder_a),
        .i_enc_b    (encoder_b),
        .o_step     (w_step),
        .o_enc_error(enc_error)
    );

    assign w_wrap     = (pwm_period != '0) && (r_cnt >= pwm_period);
    assign w_start    = w_wrap && (r_win == SP_LAST);
    assign w_acc_next = DW'(sat_s(64'(r_acc_win) + 64'(w_step), DW));

    // PWM counter, window counter and saturating speed accumulator; runs regardless of pwm_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_win        <= '0;
            r_acc_win    <= '0;
            r_speed_meas <= '0;
        end else begin
            if (pwm_period == '0)  r_cnt <= '0;
            else if (w_wrap)       r_cnt <= '0;
            else                   r_cnt <= r_cnt + 1'b1;
            if (w_wrap) r_win <= (r_win == SP_LAST) ? '0 : r_win + 1'b1;
            if (w_start) begin
                r_speed_meas <= w_acc_next;
                r_acc_win    <= DW'(w_step);
            end else begin
                r_acc_win    <= w_acc_next;
            end
        end
    end

    assign w_de    = DW1'(r_e) - DW1'(r_prev_e);
    assign w_prod  = w_mul_a * w_mul_b;
    assign w_y64   = 64'(r_acc) >>> FRAC_BITS;
    assign w_lim64 = $signed(64'(pwm_period));
    assign w_ycl64 = clamp_s(w_y64, w_lim64);
    assign w_y_sat = (w_ycl64 != w_y64);
    assign w_freeze = w_y_sat && (r_e[DW-1] == w_y64[63]);

    // Route gain and operand for the single multiplier according to the PID step.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            MP:      begin w_mul_a = $signed({1'b0, r_kp}); w_mul_b = DW1'(r_e);        end
            MI:      begin w_mul_a = $signed({1'b0, r_ki}); w_mul_b = DW1'(r_integral); end
            MD:      begin w_mul_a = $signed({1'b0, r_kd}); w_mul_b = w_de;             end
            default: begin w_mul_a = '0;                    w_mul_b = '0;               end
        endcase
    end

    // PID sequencer: error, three MAC steps, then scale/clamp and integral update with anti-windup.
    always_ff @(posedge clk) begin
        if (reset || !pwm_en) begin
            r_state    <= IDLE;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
            r_e        <= '0;
            r_prev_e   <= '0;
            r_integral <= '0;
            r_acc      <= '0;
            r_duty_cmd <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_kp    <= Kp;
                    r_ki    <= Ki;
                    r_kd    <= Kd;
                    r_state <= ERR;
                end
                ERR: begin
                    r_e     <= DW'(sat_s(64'($signed(speed_reference)) - 64'(r_speed_meas), DW));
                    r_state <= MP;
                end
                MP: begin
                    r_acc   <= AW'(w_prod);
                    r_state <= MI;
                end
                MI: begin
                    r_acc   <= r_acc + AW'(w_prod);
                    r_state <= MD;
                end
                MD: begin
                    r_acc   <= r_acc + AW'(w_prod);
                    r_state <= OUT;
                end
                OUT: begin
                    r_duty_cmd <= DW1'(w_ycl64);
                    r_prev_e   <= r_e;
                    if (!w_freeze)
                        r_integral <= DW'(clamp_s(64'(r_integral) + 64'(r_e), INT_LIM64));
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_duty_mag = r_duty_active[DW] ? DW1'(-r_duty_active) : DW1'(r_duty_active);
    assign w_pwm      = pwm_en && (pwm_period != '0) && ({1'b0, r_cnt} < w_duty_mag);
    assign w_want_dir = r_duty_active[DW] ? REV : FWD;

    // Glitch-free duty load at period wrap, and registered legs with deadtime on reversal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty_active <= '0;
            r_dir         <= FWD;
            r_dt_cnt      <= '0;
            r_mpos        <= 1'b0;
            r_mneg        <= 1'b0;
        end else begin
            if (!pwm_en)     r_duty_active <= '0;
            else if (w_wrap) r_duty_active <= r_duty_cmd;
            if (w_want_dir != r_dir) begin
                r_dir    <= w_want_dir;
                r_dt_cnt <= DT_LOAD;
                r_mpos   <= 1'b0;
                r_mneg   <= 1'b0;
            end else if (r_dt_cnt != '0) begin
                r_dt_cnt <= r_dt_cnt - 1'b1;
                r_mpos   <= 1'b0;
                r_mneg   <= 1'b0;
            end else begin
                r_mpos   <= (r_dir == FWD) && w_pwm;
                r_mneg   <= (r_dir == REV) && w_pwm;
            end
        end
    end

    assign motor_positive = r_mpos;
    assign motor_negative = r_mneg;
    assign speed_meas     = r_speed_meas;
    assign duty_cmd       = r_duty_cmd;

endmodule
